filter2d_gen: RTL and testbench
===============================

Name: filter2d_gen

Overview:
Parametrised successor to the fixed 256x256 3x3 filter engine. Reads a rectangular 8-bit-class image from single-port SRAM and convolves it with a programmable signed 3x3 kernel. Writes the rounded, saturated result back to a separate SRAM region. Adds configurable frame geometry and base addresses, a runtime border mode (zero or replicate), correct unsigned-pixel arithmetic, a busy flag, and kernel-write protection while busy.

Parameters:
IMG_W, 256, image width in pixels (>=2)
IMG_H, 256, image height in pixels (>=2)
PIX_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width (signed two's complement)
FRAC, 7, coefficient fractional bits
ADDR_W, 17, SRAM address width
RD_BASE, 0, source image base address
WR_BASE, 65536, destination image base address

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  frame start strobe
border_mode  in  1  0=zero padding, 1=replicate edge; sampled with start
busy  out  1  frame in progress
finish  out  1  one-cycle done pulse
cs  out  1  SRAM chip select
we  out  1  SRAM write enable
addr  out  ADDR_W  SRAM address
din  out  PIX_W  SRAM write data
dout  in  PIX_W  SRAM read data, valid 1 cycle after read cs
h_write  in  1  kernel coefficient write strobe
h_idx  in  4  coefficient index 0..8, row-major, 0=top-left
h_data  in  COEF_W  coefficient value

Behaviour:
- Reset: one clock, synchronous active-low. On the edge where reset_n=0: busy=0, finish=0, all counters 0, acc=0, mode=0, h[0..8]=8,16,8,16,32,16,8,16,8 (Q1.7 Gaussian, sum 128). cs/we are 0 while idle. Reset mid-frame aborts immediately; no further SRAM access; no finish pulse.
- Kernel: h_write with h_idx<=8 while busy=0 updates h[h_idx] on the next edge. Writes with h_idx>8, or while busy=1, are ignored.
- Start: start with busy=0 at edge T latches border_mode, sets busy=1, and sets cnt=0, x=0, y=0 from T+1. start while busy=1 is ignored.
- Per-pixel schedule, 12 cycles, cnt 0..11:
  - cnt 0..8: tap k=cnt at (x+dx, y+dy), dx,dy in {-1,0,1} row-major.
  - Replicate mode: out-of-range coordinates clamp to [0,IMG_W-1]/[0,IMG_H-1]. Every tap is read (cs=1, we=0, addr=RD_BASE+yc*IMG_W+xc).
  - Zero mode: out-of-range taps issue no read (cs=0) and contribute 0.
- Pipeline: dout registered at cnt k+1. Multiply-accumulate at cnt k+2.
  - acc cleared at cnt 1.
  - Product = zero-extended pixel (PIX_W+1 bits signed) x h[k].
  - acc width PIX_W+COEF_W+4 signed; no overflow possible.
- Output:
  - res = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift).
  - Clamp: res<0 -> 0; res>2^PIX_W-1 -> 2^PIX_W-1.
- Write at cnt 11: cs=1, we=1, addr=WR_BASE+y*IMG_W+x, din=clamped result. Then cnt->0.
- Pixel order: x increments per pixel; at x=IMG_W-1 it wraps to 0 and y increments.
- Frame end: the final write (x=IMG_W-1, y=IMG_H-1, cnt=11) occurs at edge T+12*IMG_W*IMG_H. On the next cycle busy=0 and finish=1 for exactly one cycle. start may be accepted in that same finish cycle.
- Address arithmetic is in ADDR_W bits. The configuration must satisfy RD_BASE/WR_BASE + IMG_W*IMG_H <= 2^ADDR_W; no wrap checking.

Test Plan:
1. Default kernel, replicate, 8x4 constant image 100 -> all 32 outputs 100; finish at T+385; busy high T+1..T+384.
2. Default kernel, zero mode, constant 100 -> corners 56 (weight 72); non-corner edges 75 (weight 96); interior 100; no read cs on out-of-range taps.
3. Kernel h4=0x40, others 0, pixel 201 -> 101 (rounding). Pixel 255 with h4=0x80 (-128) -> 0 (negative clamp). All h=0x7F, pixel 255 -> 255 (positive clamp). Checks unsigned pixel: 255 is not treated as -1.
4. h_write during busy, and start during busy -> kernel and frame unchanged; single finish pulse.
5. Assert reset_n=0 mid-frame for 1 cycle -> next cycle busy=0, cs=0, h restored to defaults. A new start completes a full frame correctly.
6. Non-default geometry IMG_W=5, IMG_H=3, WR_BASE=64 -> writes to 64..78 in raster order; finish at T+181.

Source files
------------

// File: rtl/filter2d_gen.sv
`default_nettype none
// ============================================================================
// Module   : filter2d_gen
// Brief    : Streams an IMG_W x IMG_H unsigned image from single-port SRAM,
//            applies a programmable signed 3x3 kernel (zero or replicate
//            border), and writes the rounded, saturated result back to SRAM.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module filter2d_gen #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int PIX_W   = 8,
    parameter int COEF_W  = 8,
    parameter int FRAC    = 7,
    parameter int ADDR_W  = 17,
    parameter int RD_BASE = 0,
    parameter int WR_BASE = 65536
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     border_mode,
    output logic                     busy,
    output logic                     finish,
    output logic                     cs,
    output logic                     we,
    output logic [ADDR_W-1:0]        addr,
    output logic [PIX_W-1:0]         din,
    input  logic [PIX_W-1:0]         dout,
    input  logic                     h_write,
    input  logic [3:0]               h_idx,
    input  logic signed [COEF_W-1:0] h_data
);

    // Signed coordinate widths wide enough to hold -1 .. IMG_W (resp. IMG_H)
    localparam int c_xw     = $clog2(IMG_W) + 2;
    localparam int c_yw     = $clog2(IMG_H) + 2;
    localparam int c_acc_w  = PIX_W + COEF_W + 4;
    localparam int c_prod_w = PIX_W + 1 + COEF_W;

    localparam logic signed [c_xw-1:0]    c_x_max   = c_xw'(IMG_W - 1);
    localparam logic signed [c_yw-1:0]    c_y_max   = c_yw'(IMG_H - 1);
    localparam logic [ADDR_W-1:0]         c_rd_base = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0]         c_wr_base = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0]         c_stride  = ADDR_W'(IMG_W);
    localparam logic signed [c_acc_w-1:0] c_half    = c_acc_w'(2 ** (FRAC - 1));
    localparam logic signed [c_acc_w-1:0] c_pix_max = c_acc_w'(2 ** PIX_W - 1);

    // Q1.7 Gaussian, sum 128
    localparam logic signed [COEF_W-1:0] c_h_def [9] = '{
        COEF_W'(8),  COEF_W'(16), COEF_W'(8),
        COEF_W'(16), COEF_W'(32), COEF_W'(16),
        COEF_W'(8),  COEF_W'(16), COEF_W'(8)
    };

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                     r_state;
    logic                       r_mode;
    logic                       r_finish;
    logic [3:0]                 r_cnt;
    logic signed [c_xw-1:0]     r_x;
    logic signed [c_yw-1:0]     r_y;
    logic signed [c_acc_w-1:0]  r_acc;
    logic [PIX_W-1:0]           r_pix;
    logic                       r_vld;
    logic signed [COEF_W-1:0]   r_h [9];

    logic signed [c_xw-1:0]     w_dx;
    logic signed [c_yw-1:0]     w_dy;
    logic signed [c_xw-1:0]     w_tx;
    logic signed [c_yw-1:0]     w_ty;
    logic signed [c_xw-1:0]     w_xc;
    logic signed [c_yw-1:0]     w_yc;
    logic                       w_tap_ok;
    logic                       w_tap_phase;
    logic                       w_wr_phase;
    logic [ADDR_W-1:0]          w_rd_addr;
    logic [ADDR_W-1:0]          w_wr_addr;
    logic [3:0]                 w_mac_idx;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_rnd;
    logic signed [c_acc_w-1:0]  w_shift;
    logic [PIX_W-1:0]           w_res;

    assign busy        = (r_state == S_RUN);
    assign finish      = r_finish;
    assign w_tap_phase = busy && (r_cnt <= 4'd8);
    assign w_wr_phase  = busy && (r_cnt == 4'd11);

    // Tap offset for the current cycle, row-major over the 3x3 window
    always_comb begin
        w_dx = c_xw'(1);
        w_dy = c_yw'(1);
        case (r_cnt)
            4'd0, 4'd3, 4'd6: w_dx = {c_xw{1'b1}};
            4'd1, 4'd4, 4'd7: w_dx = '0;
            default:          w_dx = c_xw'(1);
        endcase
        if (r_cnt < 4'd3) begin
            w_dy = {c_yw{1'b1}};
        end else if (r_cnt < 4'd6) begin
            w_dy = '0;
        end
    end

    // Tap coordinate, clamped copy for replicate mode, and in-range test
    always_comb begin
        w_tx = r_x + w_dx;
        w_ty = r_y + w_dy;
        w_xc = w_tx[c_xw-1] ? '0 : ((w_tx > c_x_max) ? c_x_max : w_tx);
        w_yc = w_ty[c_yw-1] ? '0 : ((w_ty > c_y_max) ? c_y_max : w_ty);
        w_tap_ok = r_mode
                || (!w_tx[c_xw-1] && (w_tx <= c_x_max)
                    && !w_ty[c_yw-1] && (w_ty <= c_y_max));
    end

    assign w_rd_addr = c_rd_base + ADDR_W'(w_yc) * c_stride + ADDR_W'(w_xc);
    assign w_wr_addr = c_wr_base + ADDR_W'(r_y) * c_stride + ADDR_W'(r_x);

    // Pixel is zero-extended so 2^PIX_W-1 stays positive in the product
    assign w_mac_idx = ((r_cnt >= 4'd2) && (r_cnt <= 4'd10)) ? (r_cnt - 4'd2) : 4'd0;
    assign w_prod    = $signed({1'b0, r_pix}) * r_h[w_mac_idx];

    // Round half up, arithmetic shift, then saturate into the pixel range
    always_comb begin
        w_rnd   = r_acc + c_half;
        w_shift = w_rnd >>> FRAC;
        if (w_shift[c_acc_w-1]) begin
            w_res = '0;
        end else if (w_shift > c_pix_max) begin
            w_res = {PIX_W{1'b1}};
        end else begin
            w_res = w_shift[PIX_W-1:0];
        end
    end

    assign cs   = (w_tap_phase && w_tap_ok) || w_wr_phase;
    assign we   = w_wr_phase;
    assign addr = w_wr_phase ? w_wr_addr : (cs ? w_rd_addr : '0);
    assign din  = w_res;

    // Control FSM, pixel walk, read pipeline, accumulator and kernel storage
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_mode   <= 1'b0;
            r_finish <= 1'b0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_pix    <= '0;
            r_vld    <= 1'b0;
            r_h      <= c_h_def;
        end else begin
            r_finish <= 1'b0;
            // Read data is only kept when a real read was issued last cycle
            r_vld    <= w_tap_phase && w_tap_ok;
            r_pix    <= r_vld ? dout : '0;

            if (h_write && !busy && (h_idx <= 4'd8)) begin
                r_h[h_idx] <= h_data;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mode  <= border_mode;
                        r_cnt   <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_RUN: begin
                    if (r_cnt == 4'd1) begin
                        r_acc <= '0;
                    end else if ((r_cnt >= 4'd2) && (r_cnt <= 4'd10)) begin
                        r_acc <= r_acc + c_acc_w'(w_prod);
                    end

                    if (r_cnt == 4'd11) begin
                        r_cnt <= '0;
                        if (r_x == c_x_max) begin
                            r_x <= '0;
                            if (r_y == c_y_max) begin
                                r_y      <= '0;
                                r_state  <= S_IDLE;
                                r_finish <= 1'b1;
                            end else begin
                                r_y <= r_y + c_yw'(1);
                            end
                        end else begin
                            r_x <= r_x + c_xw'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter2d_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter2d_gen
// Brief    : Directed self-checking bench for filter2d_gen. Instance A is an
//            8x4 frame, instance B a 5x3 frame at WR_BASE 64; each has its
//            own SRAM model that logs reads and writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter2d_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       border_mode;
    logic       h_write;
    logic [3:0] h_idx;
    logic [7:0] h_data;
    logic       sel;

    always #5 clk = ~clk;

    // Instance A wiring
    logic       start_a, h_write_a, busy_a, finish_a, cs_a, we_a;
    logic [7:0] addr_a, din_a;
    logic [7:0] dout_a = 8'h00;
    // Instance B wiring
    logic       start_b, h_write_b, busy_b, finish_b, cs_b, we_b;
    logic [6:0] addr_b;
    logic [7:0] din_b;
    logic [7:0] dout_b = 8'h00;

    assign start_a   = start & ~sel;
    assign start_b   = start & sel;
    assign h_write_a = h_write & ~sel;
    assign h_write_b = h_write & sel;

    logic busy, finish, cs, we;
    assign busy   = sel ? busy_b   : busy_a;
    assign finish = sel ? finish_b : finish_a;
    assign cs     = sel ? cs_b     : cs_a;
    assign we     = sel ? we_b     : we_a;

    filter2d_gen #(
        .IMG_W(8), .IMG_H(4), .PIX_W(8), .COEF_W(8), .FRAC(7),
        .ADDR_W(8), .RD_BASE(0), .WR_BASE(128)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .border_mode(border_mode),
        .busy(busy_a), .finish(finish_a), .cs(cs_a), .we(we_a),
        .addr(addr_a), .din(din_a), .dout(dout_a),
        .h_write(h_write_a), .h_idx(h_idx), .h_data(h_data)
    );

    filter2d_gen #(
        .IMG_W(5), .IMG_H(3), .PIX_W(8), .COEF_W(8), .FRAC(7),
        .ADDR_W(7), .RD_BASE(0), .WR_BASE(64)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .border_mode(border_mode),
        .busy(busy_b), .finish(finish_b), .cs(cs_b), .we(we_b),
        .addr(addr_b), .din(din_b), .dout(dout_b),
        .h_write(h_write_b), .h_idx(h_idx), .h_data(h_data)
    );

    // SRAM models: source image arrays plus write logs
    logic [7:0] src_a [32];
    logic [7:0] src_b [15];
    logic [7:0] wa_a [512];
    logic [7:0] wd_a [512];
    logic [7:0] wa_b [64];
    logic [7:0] wd_b [64];
    int rd_a = 0, bad_a = 0, nw_a = 0;
    int rd_b = 0, bad_b = 0, nw_b = 0;

    always @(posedge clk) begin
        if (cs_a && !we_a) begin
            rd_a <= rd_a + 1;
            if (addr_a < 8'd32) dout_a <= src_a[addr_a[4:0]];
            else begin bad_a <= bad_a + 1; dout_a <= 8'hEE; end
        end
        if (cs_a && we_a && nw_a < 512) begin
            wa_a[nw_a] <= addr_a;
            wd_a[nw_a] <= din_a;
            nw_a <= nw_a + 1;
        end
    end

    always @(posedge clk) begin
        if (cs_b && !we_b) begin
            rd_b <= rd_b + 1;
            if (addr_b < 7'd15) dout_b <= src_b[addr_b[3:0]];
            else begin bad_b <= bad_b + 1; dout_b <= 8'hEE; end
        end
        if (cs_b && we_b && nw_b < 64) begin
            wa_b[nw_b] <= {1'b0, addr_b};
            wd_b[nw_b] <= din_b;
            nw_b <= nw_b + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_v [32];
    int cyc, bsy, fins, n0, r0, w0, seen;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_coef(input int idx, input int val);
        h_write = 1'b1;
        h_idx   = 4'(idx);
        h_data  = 8'(val);
        @(posedge clk); #1;
        h_write = 1'b0;
    endtask

    task automatic fill_a(input int v);
        for (int i = 0; i < 32; i++) src_a[i] = 8'(v);
    endtask

    task automatic set_default_kernel();
        int def [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
        for (int k = 0; k < 9; k++) write_coef(k, def[k]);
    endtask

    // Start a frame on the selected instance and wait for its finish pulse
    task automatic run_frame(input logic mode, output int c, output int b, output int f);
        border_mode = mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0; b = 0; f = 0;
        while (c < 2000) begin
            if (busy) b++;
            if (finish) begin f++; break; end
            @(posedge clk); #1;
            c++;
        end
        if (c >= 2000) check_value("frame timeout", 32'(c), 32'd0);
        @(posedge clk); #1;
        if (finish) f++;
    endtask

    task automatic check_writes(input string tag, input int first, input int npix, input int base);
        int nw;
        logic [7:0] a, d;
        nw = sel ? nw_b : nw_a;
        check_value({tag, " write count"}, 32'(nw - first), 32'(npix));
        for (int i = 0; i < npix; i++) begin
            if (first + i < 64 || (!sel && first + i < 512)) begin
                a = sel ? wa_b[first + i] : wa_a[first + i];
                d = sel ? wd_b[first + i] : wd_a[first + i];
                check_value($sformatf("%s addr[%0d]", tag, i), 32'(a), 32'(base + i));
                check_value($sformatf("%s data[%0d]", tag, i), 32'(d), 32'(exp_v[i]));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; border_mode = 1'b0; sel = 1'b0;
        h_write = 1'b0; h_idx = 4'd0; h_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset busy",   32'(busy_a),   32'd0);
        check_value("reset finish", 32'(finish_a), 32'd0);
        check_value("reset cs",     32'(cs_a),     32'd0);
        check_value("reset we",     32'(we_a),     32'd0);
        check_value("reset busy b", 32'(busy_b),   32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: default kernel, replicate, constant 100
        fill_a(100);
        n0 = nw_a; r0 = rd_a;
        run_frame(1'b1, cyc, bsy, fins);
        check_value("t1 finish cycle", 32'(cyc), 32'd384);
        check_value("t1 busy cycles",  32'(bsy), 32'd384);
        check_value("t1 finish pulses", 32'(fins), 32'd1);
        check_value("t1 reads", 32'(rd_a - r0), 32'd288);
        for (int i = 0; i < 32; i++) exp_v[i] = 100;
        check_writes("t1", n0, 32, 128);

        // 2: zero padding, constant 100: corners 56, edges 75, interior 100
        n0 = nw_a; r0 = rd_a;
        run_frame(1'b0, cyc, bsy, fins);
        check_value("t2 reads", 32'(rd_a - r0), 32'd220);
        check_value("t2 bad reads", 32'(bad_a), 32'd0);
        for (int i = 0; i < 32; i++) begin
            automatic int x = i % 8;
            automatic int y = i / 8;
            automatic bit bx = (x == 0) || (x == 7);
            automatic bit by = (y == 0) || (y == 3);
            exp_v[i] = (bx && by) ? 56 : ((bx || by) ? 75 : 100);
        end
        check_writes("t2", n0, 32, 128);

        // 3a: center 0x40, pixel 201 -> 101
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 64 : 0);
        fill_a(201);
        n0 = nw_a;
        run_frame(1'b1, cyc, bsy, fins);
        for (int i = 0; i < 32; i++) exp_v[i] = 101;
        check_writes("t3a", n0, 32, 128);

        // 3b: center -128, pixel 255 -> clamps to 0
        write_coef(4, 8'h80);
        fill_a(255);
        n0 = nw_a;
        run_frame(1'b1, cyc, bsy, fins);
        for (int i = 0; i < 32; i++) exp_v[i] = 0;
        check_writes("t3b", n0, 32, 128);

        // 3c: all 0x7F, pixel 255 -> clamps to 255
        for (int k = 0; k < 9; k++) write_coef(k, 8'h7F);
        n0 = nw_a;
        run_frame(1'b1, cyc, bsy, fins);
        for (int i = 0; i < 32; i++) exp_v[i] = 255;
        check_writes("t3c", n0, 32, 128);

        // 4: out-of-range index ignored; kernel write, start and mode change during busy ignored
        set_default_kernel();
        write_coef(12, 0);
        fill_a(100);
        n0 = nw_a;
        fork
            run_frame(1'b1, cyc, bsy, fins);
            begin
                repeat (40) @(posedge clk);
                #1;
                h_write = 1'b1; h_idx = 4'd4; h_data = 8'd0;
                start = 1'b1; border_mode = 1'b0;
                @(posedge clk); #1;
                h_write = 1'b0; start = 1'b0;
            end
        join
        check_value("t4 finish cycle", 32'(cyc), 32'd384);
        check_value("t4 finish pulses", 32'(fins), 32'd1);
        for (int i = 0; i < 32; i++) exp_v[i] = 100;
        check_writes("t4", n0, 32, 128);
        @(posedge clk); #1;
        check_value("t4 no restart", 32'(busy_a), 32'd0);

        // 5: reset mid-frame aborts and restores the default kernel
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 64 : 0);
        border_mode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_value("t5 busy after reset", 32'(busy_a), 32'd0);
        check_value("t5 cs after reset",   32'(cs_a),   32'd0);
        r0 = rd_a; w0 = nw_a; seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (cs_a || finish_a || busy_a) seen++;
        end
        check_value("t5 idle activity", 32'(seen), 32'd0);
        check_value("t5 reads after reset", 32'(rd_a - r0), 32'd0);
        check_value("t5 writes after reset", 32'(nw_a - w0), 32'd0);
        n0 = nw_a;
        run_frame(1'b1, cyc, bsy, fins);
        check_value("t5 finish cycle", 32'(cyc), 32'd384);
        check_writes("t5", n0, 32, 128);

        // 6: 5x3 geometry, impulse 128 at (2,1), kernel h[k]=k+1 -> reversed kernel
        sel = 1'b1;
        for (int k = 0; k < 9; k++) write_coef(k, k + 1);
        for (int i = 0; i < 15; i++) src_b[i] = 8'd0;
        src_b[7] = 8'd128;
        n0 = nw_b; r0 = rd_b;
        run_frame(1'b1, cyc, bsy, fins);
        check_value("t6 finish cycle", 32'(cyc), 32'd180);
        check_value("t6 busy cycles", 32'(bsy), 32'd180);
        check_value("t6 finish pulses", 32'(fins), 32'd1);
        check_value("t6 reads", 32'(rd_b - r0), 32'd135);
        check_value("t6 bad reads", 32'(bad_b), 32'd0);
        exp_v[0]  = 0; exp_v[1]  = 9; exp_v[2]  = 8; exp_v[3]  = 7; exp_v[4]  = 0;
        exp_v[5]  = 0; exp_v[6]  = 6; exp_v[7]  = 5; exp_v[8]  = 4; exp_v[9]  = 0;
        exp_v[10] = 0; exp_v[11] = 3; exp_v[12] = 2; exp_v[13] = 1; exp_v[14] = 0;
        check_writes("t6", n0, 15, 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
